// File: rtl/jk_counter_pkg.sv
// +---------------------------------------------------------------------------+
// | jk_counter_pkg : JK excitation commands and helper functions shared by      |
// |                  the modulo counter and its storage cells.                  |
// | Revision       : 1.0                                                        |
// +---------------------------------------------------------------------------+
`default_nettype none

package jk_counter_pkg;

   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_cmd_t;

   // Forced updates (load, wrap) drive the target value explicitly rather than
   // relying on the current bit, so they are correct whatever the cell holds.
   function automatic jk_cmd_t jk_cmd_sel(input logic cur_bit,
                                          input logic next_bit,
                                          input logic force_cmd);
      jk_cmd_t cmd;
      if (force_cmd) begin
         cmd = next_bit ? JK_SET : JK_RESET;
      end else if (cur_bit == next_bit) begin
         cmd = JK_HOLD;
      end else begin
         cmd = JK_TOGGLE;
      end
      return cmd;
   endfunction

   // Returns {J, K}.
   function automatic logic [1:0] jk_cmd_to_jk(input jk_cmd_t cmd);
      logic [1:0] jk;
      case (cmd)
         JK_HOLD:   jk = 2'b00;
         JK_RESET:  jk = 2'b01;
         JK_SET:    jk = 2'b10;
         JK_TOGGLE: jk = 2'b11;
         default:   jk = 2'b00;
      endcase
      return jk;
   endfunction

endpackage

`default_nettype wire

// File: rtl/jk_cell.sv
// +---------------------------------------------------------------------------+
// | jk_cell  : single JK storage bit, asynchronous active-low reset to 0.       |
// | Revision : 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module jk_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b00:   q <= q;
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/jk_mod_counter.sv
// +---------------------------------------------------------------------------+
// | jk_mod_counter : modulo-MODULUS up/down counter on a bank of JK cells.      |
// |                  Build option JK_MOD_COUNTER_SAT_EN saturates at the ends.  |
// | Revision       : 1.0                                                        |
// +---------------------------------------------------------------------------+
`default_nettype none

module jk_mod_counter
   import jk_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   // One extra bit so MODULUS = 2**WIDTH is representable in the compares.
   localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

   logic [WIDTH:0]   cur_ext;
   logic [WIDTH:0]   load_ext;
   logic [WIDTH:0]   next_ext;
   logic [WIDTH-1:0] next_val;
   logic             unused_next_msb;
   logic             force_cmd;
   logic             tc_next;
   logic             ovf_next;
   logic [WIDTH-1:0] q_vec;
   logic [WIDTH-1:0] j_vec;
   logic [WIDTH-1:0] k_vec;

   assign cur_ext  = {1'b0, q_vec};
   assign load_ext = {1'b0, load_val};

   always_comb begin
      next_ext  = cur_ext;
      force_cmd = 1'b0;
      tc_next   = 1'b0;
      ovf_next  = ovf;
      if (load) begin
         force_cmd = 1'b1;
         if (load_ext >= MOD_EXT) begin
            next_ext = MAX_EXT;
            ovf_next = 1'b1;
         end else begin
            next_ext = load_ext;
            ovf_next = 1'b0;
         end
      end else if (en) begin
         if (up) begin
            if (cur_ext >= MAX_EXT) begin
`ifdef JK_MOD_COUNTER_SAT_EN
               next_ext  = cur_ext;
`else
               next_ext  = '0;
               force_cmd = 1'b1;
`endif
               tc_next  = 1'b1;
               ovf_next = 1'b1;
            end else begin
               next_ext = cur_ext + 1'b1;
            end
         end else begin
            if (cur_ext == '0) begin
`ifdef JK_MOD_COUNTER_SAT_EN
               next_ext  = cur_ext;
`else
               next_ext  = MAX_EXT;
               force_cmd = 1'b1;
`endif
               tc_next  = 1'b1;
               ovf_next = 1'b1;
            end else begin
               next_ext = cur_ext - 1'b1;
            end
         end
      end
   end

   assign next_val        = next_ext[WIDTH-1:0];
   assign unused_next_msb = next_ext[WIDTH];

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_cmd_t    cmd;
      logic [1:0] jk;

      assign cmd      = jk_cmd_sel(q_vec[i], next_val[i], force_cmd);
      assign jk       = jk_cmd_to_jk(cmd);
      assign j_vec[i] = jk[1];
      assign k_vec[i] = jk[0];

      jk_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .j     (j_vec[i]),
         .k     (k_vec[i]),
         .q     (q_vec[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tc  <= 1'b0;
         ovf <= 1'b0;
      end else begin
         tc  <= tc_next;
         ovf <= ovf_next;
      end
   end

   assign count = q_vec;

endmodule

`default_nettype wire

// File: tb/tb_jk_mod_counter.sv
// Directed bench: WIDTH=4/MODULUS=10 instance plus WIDTH=3/MODULUS=8 full-range instance.
`default_nettype none

module tb_jk_mod_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en_a, up_a, load_a;
   logic [3:0] load_val_a;
   logic [3:0] count_a;
   logic       tc_a, ovf_a;
   logic       en_b, up_b, load_b;
   logic [2:0] load_val_b;
   logic [2:0] count_b;
   logic       tc_b, ovf_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en_a),
      .up       (up_a),
      .load     (load_a),
      .load_val (load_val_a),
      .count    (count_a),
      .tc       (tc_a),
      .ovf      (ovf_a)
   );

   jk_mod_counter #(.WIDTH(3), .MODULUS(8)) u_dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en_b),
      .up       (up_b),
      .load     (load_b),
      .load_val (load_val_b),
      .count    (count_b),
      .tc       (tc_b),
      .ovf      (ovf_b)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input int c, input logic t, input logic o);
      chk({tag, ".count"}, 16'(count_a), 16'(c));
      chk({tag, ".tc"},    16'(tc_a),    16'(t));
      chk({tag, ".ovf"},   16'(ovf_a),   16'(o));
   endtask

   task automatic chk_b(input string tag, input int c, input logic t, input logic o);
      chk({tag, ".count"}, 16'(count_b), 16'(c));
      chk({tag, ".tc"},    16'(tc_b),    16'(t));
      chk({tag, ".ovf"},   16'(ovf_b),   16'(o));
   endtask

   initial begin
      rst_n = 1'b0;
      en_a = 0; up_a = 1; load_a = 0; load_val_a = '0;
      en_b = 0; up_b = 1; load_b = 0; load_val_b = '0;
      step();
      step();
      chk_a("reset_a", 0, 0, 0);
      chk_b("reset_b", 0, 0, 0);

      rst_n = 1'b1;
      en_a  = 1;
      up_a  = 1;
`ifndef JK_MOD_COUNTER_SAT_EN
      for (int i = 1; i <= 9; i++) begin
         step();
         chk_a($sformatf("up_%0d", i), i, 0, 0);
      end
      step();
      chk_a("up_wrap", 0, 1, 1);
      step();
      chk_a("up_after_wrap", 1, 0, 1);

      for (int i = 2; i <= 7; i++) step();
      chk_a("pre_reset", 7, 0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_a("async_reset", 0, 0, 0);
      @(posedge clk);
      #1;
      chk_a("held_reset", 0, 0, 0);
      rst_n = 1'b1;
      step();
      chk_a("first_after_reset", 1, 0, 0);

      en_a = 0; load_a = 1; load_val_a = 4'd0;
      step();
      chk_a("load_0", 0, 0, 0);
      load_a = 0; en_a = 1; up_a = 0;
      step();
      chk_a("down_wrap", 9, 1, 1);
      step();
      chk_a("down_8", 8, 0, 1);

      en_a = 0; load_a = 1; load_val_a = 4'd5;
      step();
      chk_a("load_5", 5, 0, 0);
      load_a = 0; en_a = 1;
      up_a = 0; step(); chk_a("dir_4a", 4, 0, 0);
      up_a = 1; step(); chk_a("dir_5a", 5, 0, 0);
      up_a = 0; step(); chk_a("dir_4b", 4, 0, 0);
      up_a = 1; step(); chk_a("dir_5b", 5, 0, 0);
`endif

      en_a = 0; load_a = 1; load_val_a = 4'd12;
      step();
      chk_a("load_clamp", 9, 0, 1);
      en_a = 1; up_a = 1; load_val_a = 4'd3;
      step();
      chk_a("load_over_en", 3, 0, 0);
      load_val_a = 4'd9;
      step();
      chk_a("load_terminal", 9, 0, 0);
      load_a = 0; en_a = 0;
      step();
      chk_a("hold", 9, 0, 0);

      load_b = 1; load_val_b = 3'd0;
      step();
      chk_b("b_load_0", 0, 0, 0);
      load_b = 0; en_b = 1; up_b = 1;
`ifndef JK_MOD_COUNTER_SAT_EN
      for (int i = 1; i <= 7; i++) begin
         step();
         chk_b($sformatf("b_up_%0d", i), i, 0, 0);
      end
      step();
      chk_b("b_up_wrap", 0, 1, 1);
      up_b = 0;
      step();
      chk_b("b_down_wrap", 7, 1, 1);
      step();
      chk_b("b_down_6", 6, 0, 1);
`else
      load_a = 1; load_val_a = 4'd8;
      step();
      chk_a("sat_load_8", 8, 0, 0);
      load_a = 0; en_a = 1; up_a = 1;
      step(); chk_a("sat_up_9", 9, 0, 0);
      step(); chk_a("sat_pin_1", 9, 1, 1);
      step(); chk_a("sat_pin_2", 9, 1, 1);
      en_a = 0;
      step(); chk_a("sat_idle", 9, 0, 1);
      load_a = 1; load_val_a = 4'd0;
      step(); chk_a("sat_load_0", 0, 0, 0);
      load_a = 0; en_a = 1; up_a = 0;
      step(); chk_a("sat_down_pin", 0, 1, 1);
      step(); chk_a("sat_down_pin2", 0, 1, 1);
      en_b = 0; load_b = 1; load_val_b = 3'd7;
      step(); chk_b("b_sat_load_7", 7, 0, 0);
      load_b = 0; en_b = 1; up_b = 1;
      step(); chk_b("b_sat_pin", 7, 1, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
